// File: rtl/boton_pkg.sv
// boton_pkg: shared FSM encodings, board timing defaults and hold-progress levels for button conditioners
package boton_pkg;
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_HELD        = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } estado_t;
  localparam int DEB_CYC_50MHZ = 1_000_000;
  localparam int HOLD_CYC_5S   = 250_000_000;
  localparam logic [1:0] NIVEL_0 = 2'd0;
  localparam logic [1:0] NIVEL_1 = 2'd1;
  localparam logic [1:0] NIVEL_2 = 2'd2;
  localparam logic [1:0] NIVEL_3 = 2'd3;
endpackage

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for an asynchronous input
// Ports: clk clock; reset async active-high (loads RST_VAL); d async input; q synchronized output.
module sincronizador_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, m} <= {2{RST_VAL}};
    else       {q, m} <= {m, d};
endmodule

// File: rtl/boton_acondicionador.sv
// boton_acondicionador: synchronize, debounce and classify one push-button into short/long press pulses
// Ports: clk clock; reset async active-high; boton_in raw pin; presionado debounced level;
//        pulso_corto one-cycle short-press pulse on release; pulso_largo one-cycle long-hold pulse;
//        cuenta_hold 2-bit hold progress (quarters of HOLD_CYC, 0 when not pressed).
// Optional: define BOTON_REPEAT_EN to repeat pulso_largo every REPEAT_CYC cycles while held.
module boton_acondicionador
  import boton_pkg::*;
#(
  parameter int DEB_CYC    = DEB_CYC_50MHZ,
  parameter int HOLD_CYC   = HOLD_CYC_5S,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int REPEAT_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_in,
  output logic       presionado,
  output logic       pulso_corto,
  output logic       pulso_largo,
  output logic [1:0] cuenta_hold
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  if (DEB_CYC < 2 || HOLD_CYC <= DEB_CYC || REPEAT_CYC < 1) begin : g_bad_cfg
    $error("boton_acondicionador: invalid DEB_CYC/HOLD_CYC/REPEAT_CYC");
  end
  estado_t state, state_n;
  logic origen_held, origen_n;
  logic [DW-1:0] deb_cnt, deb_n, deb_inc;
  logic [HW-1:0] hold_cnt, hold_n, hold_inc;
  logic sq, s, deb_done, long_hit, rep_hit, pres_n, corto_n;
  sincronizador_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (boton_in),
    .q     (sq)
  );
  assign s        = sq ^ ACTIVE_LOW;
  // the cycle that enters a debounce state is the first stable sample, so DEB_CYC samples end at DEB_CYC-2
  assign deb_done = deb_cnt == DW'(DEB_CYC - 2);
  assign deb_inc  = deb_cnt == DW'(DEB_CYC) ? deb_cnt : deb_cnt + DW'(1);
  assign hold_inc = hold_cnt == HW'(HOLD_CYC) ? hold_cnt : hold_cnt + HW'(1);
  // a press not yet classified as long reaches the threshold, even while its release is being debounced
  assign long_hit = hold_cnt == HW'(HOLD_CYC - 1) &&
                    (state == ST_PRESSED || (state == ST_DEB_RELEASE && !origen_held));
  assign cuenta_hold = !presionado                      ? NIVEL_0 :
                       hold_cnt >= HW'(3 * HOLD_CYC / 4) ? NIVEL_3 :
                       hold_cnt >= HW'(HOLD_CYC / 2)     ? NIVEL_2 :
                       hold_cnt >= HW'(HOLD_CYC / 4)     ? NIVEL_1 : NIVEL_0;
`ifdef BOTON_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  logic [RW-1:0] rep_cnt;
  assign rep_hit = state == ST_HELD && rep_cnt == RW'(REPEAT_CYC - 1);
  // frozen outside HELD so a bounced release resumes the repeat cadence
  always_ff @(posedge clk or posedge reset)
    if (reset)                  rep_cnt <= '0;
    else if (long_hit)          rep_cnt <= '0;
    else if (state == ST_HELD)  rep_cnt <= rep_hit ? '0 : rep_cnt + RW'(1);
`else
  assign rep_hit = 1'b0;
`endif
  always_comb begin
    state_n  = state;
    origen_n = origen_held | long_hit;
    deb_n    = deb_cnt;
    hold_n   = hold_cnt;
    pres_n   = presionado;
    corto_n  = 1'b0;
    case (state)
      ST_IDLE: if (s) begin
        state_n = ST_DEB_PRESS;
        deb_n   = '0;
      end
      ST_DEB_PRESS:
        if (!s) state_n = ST_IDLE;
        else if (deb_done) begin
          state_n = ST_PRESSED;
          pres_n  = 1'b1;
          hold_n  = '0;
        end else deb_n = deb_inc;
      ST_PRESSED: begin
        hold_n = hold_inc;
        if (long_hit) state_n = ST_HELD;
        else if (!s) begin
          state_n  = ST_DEB_RELEASE;
          origen_n = 1'b0;
          deb_n    = '0;
        end
      end
      ST_HELD: if (!s) begin
        state_n  = ST_DEB_RELEASE;
        origen_n = 1'b1;
        deb_n    = '0;
      end
      ST_DEB_RELEASE: begin
        hold_n = hold_inc;
        if (s) begin
          state_n = origen_n ? ST_HELD : ST_PRESSED;
          deb_n   = '0;
        end else if (deb_done) begin
          state_n = ST_IDLE;
          pres_n  = 1'b0;
          hold_n  = '0;
          corto_n = !origen_n;
        end else deb_n = deb_inc;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= ST_IDLE;
      origen_held <= 1'b0;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      presionado  <= 1'b0;
      pulso_corto <= 1'b0;
      pulso_largo <= 1'b0;
    end else begin
      state       <= state_n;
      origen_held <= origen_n;
      deb_cnt     <= deb_n;
      hold_cnt    <= hold_n;
      presionado  <= pres_n;
      pulso_corto <= corto_n;
      pulso_largo <= long_hit | rep_hit;
    end
endmodule

// File: tb/tb_boton_acondicionador.sv
// tb_boton_acondicionador: directed self-checking bench for boton_acondicionador (DEB_CYC=4, HOLD_CYC=20)
module tb_boton_acondicionador;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic boton_in = 1'b1;
  logic presionado, pulso_corto, pulso_largo;
  logic [1:0] cuenta_hold;
  int passed = 0;
  int total = 0;
  int cyc, t_rise, t_fall, n_fall, t_corto, n_corto, t_largo, n_largo, n_both;
  logic prev_pres;
  logic [1:0] ch [0:127];
  always #5 clk = ~clk;
  boton_acondicionador #(
    .DEB_CYC    (4),
    .HOLD_CYC   (20),
    .ACTIVE_LOW (1'b1),
    .REPEAT_CYC (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .boton_in    (boton_in),
    .presionado  (presionado),
    .pulso_corto (pulso_corto),
    .pulso_largo (pulso_largo),
    .cuenta_hold (cuenta_hold)
  );
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic clear_obs();
    cyc = 0; t_rise = -1; t_fall = -1; n_fall = 0; t_corto = -1; n_corto = 0;
    t_largo = -1; n_largo = 0; n_both = 0; prev_pres = presionado;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 128) ch[cyc] = cuenta_hold;
    if (pulso_corto) begin n_corto++; t_corto = cyc; end
    if (pulso_largo) begin n_largo++; if (t_largo < 0) t_largo = cyc; end
    if (pulso_corto && pulso_largo) n_both++;
    if (presionado && !prev_pres) t_rise = cyc;
    if (!presionado && prev_pres) begin t_fall = cyc; n_fall++; end
    prev_pres = presionado;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic test_reset();
    idle(3);
    total++; if (presionado !== 1'b0) $display("FAIL reset_presionado: got %b want 0", presionado); else passed++;
    total++; if (pulso_corto !== 1'b0) $display("FAIL reset_corto: got %b want 0", pulso_corto); else passed++;
    total++; if (pulso_largo !== 1'b0) $display("FAIL reset_largo: got %b want 0", pulso_largo); else passed++;
    total++; if (cuenta_hold !== 2'd0) $display("FAIL reset_cuenta: got %0d want 0", cuenta_hold); else passed++;
    reset = 1'b0;
    idle(4);
  endtask
  task automatic test_clean_press(input string tag);
    clear_obs();
    boton_in = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (cyc == 10) boton_in = 1'b1;
    end
    total++; if (t_rise !== 6) $display("FAIL %s_rise: got %0d want 6", tag, t_rise); else passed++;
    total++; if (t_fall !== 16) $display("FAIL %s_fall: got %0d want 16", tag, t_fall); else passed++;
    total++; if (n_corto !== 1) $display("FAIL %s_n_corto: got %0d want 1", tag, n_corto); else passed++;
    total++; if (t_corto !== 16) $display("FAIL %s_t_corto: got %0d want 16", tag, t_corto); else passed++;
    total++; if (n_largo !== 0) $display("FAIL %s_n_largo: got %0d want 0", tag, n_largo); else passed++;
    idle(4);
  endtask
  task automatic test_glitch();
    clear_obs();
    boton_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (cyc == 3) boton_in = 1'b1;
    end
    total++; if (t_rise !== -1) $display("FAIL glitch_rise: got %0d want -1", t_rise); else passed++;
    total++; if (n_corto !== 0) $display("FAIL glitch_corto: got %0d want 0", n_corto); else passed++;
    total++; if (n_largo !== 0) $display("FAIL glitch_largo: got %0d want 0", n_largo); else passed++;
  endtask
  task automatic test_hold();
    int exp_largo;
`ifdef BOTON_REPEAT_EN
    exp_largo = 3;
`else
    exp_largo = 1;
`endif
    clear_obs();
    boton_in = 1'b0;
    for (int i = 1; i <= 56; i++) begin
      step();
      if (cyc == 40) boton_in = 1'b1;
    end
    total++; if (t_rise !== 6) $display("FAIL hold_rise: got %0d want 6", t_rise); else passed++;
    total++; if (t_largo !== 26) $display("FAIL hold_t_largo: got %0d want 26", t_largo); else passed++;
    total++; if (n_largo !== exp_largo) $display("FAIL hold_n_largo: got %0d want %0d", n_largo, exp_largo); else passed++;
    total++; if (n_corto !== 0) $display("FAIL hold_corto: got %0d want 0", n_corto); else passed++;
    total++; if (t_fall !== 46) $display("FAIL hold_fall: got %0d want 46", t_fall); else passed++;
    total++; if (ch[10] !== 2'd0) $display("FAIL hold_cuenta10: got %0d want 0", ch[10]); else passed++;
    total++; if (ch[11] !== 2'd1) $display("FAIL hold_cuenta11: got %0d want 1", ch[11]); else passed++;
    total++; if (ch[15] !== 2'd1) $display("FAIL hold_cuenta15: got %0d want 1", ch[15]); else passed++;
    total++; if (ch[16] !== 2'd2) $display("FAIL hold_cuenta16: got %0d want 2", ch[16]); else passed++;
    total++; if (ch[20] !== 2'd2) $display("FAIL hold_cuenta20: got %0d want 2", ch[20]); else passed++;
    total++; if (ch[21] !== 2'd3) $display("FAIL hold_cuenta21: got %0d want 3", ch[21]); else passed++;
    total++; if (ch[40] !== 2'd3) $display("FAIL hold_cuenta40: got %0d want 3", ch[40]); else passed++;
    total++; if (ch[50] !== 2'd0) $display("FAIL hold_cuenta50: got %0d want 0", ch[50]); else passed++;
  endtask
  task automatic test_release_bounce();
    clear_obs();
    boton_in = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (cyc >= 12 && cyc <= 16) boton_in = (cyc % 2 == 0);
    end
    total++; if (t_rise !== 6) $display("FAIL bounce_rise: got %0d want 6", t_rise); else passed++;
    total++; if (t_fall !== 22) $display("FAIL bounce_fall: got %0d want 22", t_fall); else passed++;
    total++; if (n_fall !== 1) $display("FAIL bounce_n_fall: got %0d want 1", n_fall); else passed++;
    total++; if (n_corto !== 1) $display("FAIL bounce_n_corto: got %0d want 1", n_corto); else passed++;
    total++; if (t_corto !== 22) $display("FAIL bounce_t_corto: got %0d want 22", t_corto); else passed++;
    total++; if (n_largo !== 0) $display("FAIL bounce_largo: got %0d want 0", n_largo); else passed++;
    total++; if (n_both !== 0) $display("FAIL bounce_exclusive: got %0d want 0", n_both); else passed++;
  endtask
  task automatic test_reset_mid_press();
    clear_obs();
    boton_in = 1'b0;
    idle(16);
    total++; if (cuenta_hold !== 2'd2) $display("FAIL midrst_pre_cuenta: got %0d want 2", cuenta_hold); else passed++;
    total++; if (presionado !== 1'b1) $display("FAIL midrst_pre_pres: got %b want 1", presionado); else passed++;
    reset = 1'b1;
    #1;
    total++; if (presionado !== 1'b0) $display("FAIL midrst_async_pres: got %b want 0", presionado); else passed++;
    total++; if (cuenta_hold !== 2'd0) $display("FAIL midrst_async_cuenta: got %0d want 0", cuenta_hold); else passed++;
    total++; if ({pulso_corto, pulso_largo} !== 2'b00) $display("FAIL midrst_async_pulses: got %b want 00", {pulso_corto, pulso_largo}); else passed++;
    idle(2);
    reset = 1'b0;
    t_rise = -1;
    prev_pres = presionado;
    for (int i = 19; i <= 62; i++) begin
      step();
      if (cyc == 50) boton_in = 1'b1;
    end
    total++; if (t_rise !== 24) $display("FAIL midrst_rise: got %0d want 24", t_rise); else passed++;
    total++; if (ch[28] !== 2'd0) $display("FAIL midrst_cuenta28: got %0d want 0", ch[28]); else passed++;
    total++; if (ch[29] !== 2'd1) $display("FAIL midrst_cuenta29: got %0d want 1", ch[29]); else passed++;
    total++; if (t_largo !== 44) $display("FAIL midrst_t_largo: got %0d want 44", t_largo); else passed++;
    total++; if (n_corto !== 0) $display("FAIL midrst_corto: got %0d want 0", n_corto); else passed++;
  endtask
  initial begin
    test_reset();
    test_clean_press("press");
    test_glitch();
    test_clean_press("after_glitch");
    test_hold();
    idle(4);
    test_release_bounce();
    idle(4);
    test_reset_mid_press();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
